vmem_fill_sched: RTL and testbench

- Shares the single write port of the 3-bit-colour video memory (ram1122x3, 34x33 pixels) between NREQ independent drawing requesters.
- Each requester issues a rectangle-fill command with a one-cycle start pulse and receives a one-cycle done pulse when its fill has completed, in the same continuation style as the rest of the design.
- The block arbitrates round-robin between requesters and walks the clipped rectangle one pixel per cycle, driving the RAM address, data and write-enable.

---
 rtl/vmem_pkg.sv | 37 +++
 rtl/vmem_fill_sched_rr_pick.sv | 30 +++
 rtl/vmem_fill_sched.sv | 192 +++++++++++++++++++
 tb/tb_vmem_fill_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared constants, state encoding and command payload for the video-memory fill scheduler.
package vmem_pkg;

  localparam int unsigned SCR_W      = 34;
  localparam int unsigned SCR_H      = 33;
  localparam int unsigned VMEM_DEPTH = 1122;
  localparam int unsigned VMEM_AW    = 11;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned CMD_CW     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FILL  = 2'd2,
    FIN   = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [CMD_CW-1:0]  x;
    logic [CMD_CW-1:0]  y;
    logic [CMD_CW-1:0]  w;
    logic [CMD_CW-1:0]  h;
    logic [COLOR_W-1:0] color;
  } fill_cmd_t;

  // Constant multiply by shift-and-add; k is an elaboration-time constant.
  function automatic logic [VMEM_AW-1:0] mul_const(input logic [CMD_CW-1:0] v,
                                                   input logic [31:0] k);
    logic [VMEM_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(VMEM_AW); i++) begin
      if (k[i]) acc = acc + (VMEM_AW'(v) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vmem_fill_sched_rr_pick.sv
// Combinational round-robin selector: first pending index at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o_c,
  output logic [PW-1:0]   idx_o_c,
  output logic            valid_o_c
);

  // Scan requesters starting from the pointer and take the first pending one.
  always_comb begin
    logic [PW-1:0] j;
    grant_o_c = '0;
    idx_o_c   = '0;
    valid_o_c = 1'b0;
    j         = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      j = PW'((32'(ptr_i) + 32'(i)) % NREQ);
      if (!valid_o_c && pending_i[j]) begin
        valid_o_c    = 1'b1;
        idx_o_c      = j;
        grant_o_c[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_fill_sched.sv
// Round-robin rectangle-fill scheduler sharing one video-RAM write port among requesters.
module vmem_fill_sched
  import vmem_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WIDTH  = SCR_W,
  parameter int unsigned HEIGHT = SCR_H,
  parameter int unsigned CW     = CMD_CW,
  parameter int unsigned AW     = VMEM_AW
) (
  input  logic                    Clck,
  input  logic                    Resetn,
  input  logic [NREQ-1:0]         start,
  input  logic [NREQ*CW-1:0]      cmd_x,
  input  logic [NREQ*CW-1:0]      cmd_y,
  input  logic [NREQ*CW-1:0]      cmd_w,
  input  logic [NREQ*CW-1:0]      cmd_h,
  input  logic [NREQ*COLOR_W-1:0] cmd_color,
  output logic [NREQ-1:0]         busy,
  output logic [NREQ-1:0]         done,
  output logic [AW-1:0]           mem_address,
  output logic [COLOR_W-1:0]      mem_data,
  output logic                    mem_wren
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned XW = CW + 1;

  fill_state_e        state_q, state_d;
  fill_cmd_t          slot_q [NREQ];
  fill_cmd_t          sel_c;
  logic [NREQ-1:0]    pending_q, pending_d, accept_c;
  logic [NREQ-1:0]    gmask_q, gmask_d, done_q, done_d;
  logic [PW-1:0]      ptr_q, ptr_d, g_q, g_d;
  logic [CW-1:0]      cx_q, cx_d, cy_q, cy_d, x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic [CW-1:0]      xe_c, ye_c;
  logic [XW-1:0]      xend_c, yend_c;
  logic               empty_c;
  logic [COLOR_W-1:0] col_q, col_d, data_q, data_d;
  logic [AW-1:0]      rowbase_q, rowbase_d, addr_q, addr_d;
  logic               wren_q, wren_d;
  logic [NREQ-1:0]    pick_grant_c;
  logic [PW-1:0]      pick_idx_c;
  logic               pick_valid_c;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .grant_o_c (pick_grant_c),
    .idx_o_c   (pick_idx_c),
    .valid_o_c (pick_valid_c)
  );

  // A start is only taken while that requester has nothing outstanding.
  assign accept_c = start & ~pending_q;

  // Clip the selected command to the screen and flag commands with nothing to draw.
  always_comb begin
    sel_c   = slot_q[pick_idx_c];
    xend_c  = XW'(sel_c.x) + XW'(sel_c.w) - XW'(1);
    yend_c  = XW'(sel_c.y) + XW'(sel_c.h) - XW'(1);
    xe_c    = (xend_c > XW'(WIDTH - 1))  ? CW'(WIDTH - 1)  : CW'(xend_c);
    ye_c    = (yend_c > XW'(HEIGHT - 1)) ? CW'(HEIGHT - 1) : CW'(yend_c);
    empty_c = (sel_c.w == '0) || (sel_c.h == '0) ||
              (32'(sel_c.x) >= WIDTH) || (32'(sel_c.y) >= HEIGHT);
  end

  // State register.
  always_ff @(posedge Clck or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid_c) state_d = GRANT;
      GRANT:   state_d = empty_c ? FIN : FILL;
      FILL:    if ((cx_q >= xe_q) && (cy_q >= ye_q)) state_d = FIN;
      FIN:     state_d = ((pending_q & ~gmask_q) != '0) ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; memory outputs track the state being entered.
  always_comb begin
    pending_d = pending_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    gmask_d   = gmask_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x0_d      = x0_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    col_d     = col_q;
    rowbase_d = rowbase_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    done_d    = '0;
    unique case (state_q)
      GRANT: begin
        g_d       = pick_idx_c;
        gmask_d   = pick_grant_c;
        x0_d      = CW'(sel_c.x);
        cx_d      = CW'(sel_c.x);
        cy_d      = CW'(sel_c.y);
        xe_d      = xe_c;
        ye_d      = ye_c;
        col_d     = sel_c.color;
        rowbase_d = AW'(mul_const(sel_c.y, WIDTH));
      end
      FILL: begin
        if (cx_q < xe_q) begin
          cx_d = cx_q + CW'(1);
        end else if (cy_q < ye_q) begin
          cx_d      = x0_q;
          cy_d      = cy_q + CW'(1);
          rowbase_d = rowbase_q + AW'(WIDTH);
        end
      end
      FIN: begin
        pending_d = pending_q & ~gmask_q;
        ptr_d     = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
      end
      default: ;
    endcase
    pending_d = pending_d | accept_c;
    if (state_d == FILL) begin
      wren_d = 1'b1;
      addr_d = rowbase_d + AW'(cx_d);
      data_d = col_d;
    end
    if (state_d == FIN) done_d = gmask_d;
  end

  // Datapath, command slots and registered outputs.
  always_ff @(posedge Clck or negedge Resetn) begin
    if (!Resetn) begin
      pending_q <= '0;
      ptr_q     <= '0;
      g_q       <= '0;
      gmask_q   <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      x0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      col_q     <= '0;
      rowbase_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      done_q    <= '0;
      for (int k = 0; k < int'(NREQ); k++) slot_q[k] <= '0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      gmask_q   <= gmask_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      x0_q      <= x0_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      col_q     <= col_d;
      rowbase_q <= rowbase_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      done_q    <= done_d;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (accept_c[k]) begin
          slot_q[k] <= '{x:     cmd_x[k*CW +: CW],
                         y:     cmd_y[k*CW +: CW],
                         w:     cmd_w[k*CW +: CW],
                         h:     cmd_h[k*CW +: CW],
                         color: cmd_color[k*COLOR_W +: COLOR_W]};
        end
      end
    end
  end

  assign busy        = pending_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;

endmodule

// File: tb/tb_vmem_fill_sched.sv
// Bench for vmem_fill_sched: directed scenarios plus randomized traffic against a timeline model.
module tb_vmem_fill_sched;

  localparam int NREQ = 2;
  localparam int CW   = 6;
  localparam int AW   = 11;
  localparam int SW   = 34;
  localparam int SH   = 33;

  logic                Clck;
  logic                Resetn;
  logic [NREQ-1:0]     start;
  logic [NREQ*CW-1:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [NREQ*3-1:0]   cmd_color;
  logic [NREQ-1:0]     busy, done;
  logic [AW-1:0]       mem_address;
  logic [2:0]          mem_data;
  logic                mem_wren;

  vmem_fill_sched dut (
    .Clck(Clck), .Resetn(Resetn), .start(start),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren)
  );

  initial begin
    Clck = 1'b0;
    forever #5 Clck = ~Clck;
  end

  int n_checks;
  int n_fail;
  bit chk_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int cyc;
  bit m_pend [NREQ];
  int m_x [NREQ], m_y [NREQ], m_w [NREQ], m_h [NREQ], m_c [NREQ];
  int m_ptr, m_g, m_fin, m_grant, m_rel, m_relg;
  bit m_insvc;
  int m_wr_addr [int];
  int m_wr_data [int];
  int m_done [int];
  bit acc [NREQ];
  bit others, anyp;
  int xe, ye, t;

  task automatic model_clear();
    for (int k = 0; k < NREQ; k++) m_pend[k] = 1'b0;
    m_ptr = 0; m_g = 0; m_fin = -1; m_grant = -1; m_rel = -1; m_relg = 0;
    m_insvc = 1'b0;
    m_wr_addr.delete(); m_wr_data.delete(); m_done.delete();
  endtask

  // Service the chosen requester: every clipped pixel in raster order, then the done pulse.
  task automatic model_grant();
    m_g = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (m_g < 0 && m_pend[(m_ptr + i) % NREQ]) m_g = (m_ptr + i) % NREQ;
    end
    if (m_g < 0) return;
    t = cyc + 1;
    if (!(m_w[m_g] == 0 || m_h[m_g] == 0 || m_x[m_g] >= SW || m_y[m_g] >= SH)) begin
      xe = (m_x[m_g] + m_w[m_g] - 1 < SW - 1) ? m_x[m_g] + m_w[m_g] - 1 : SW - 1;
      ye = (m_y[m_g] + m_h[m_g] - 1 < SH - 1) ? m_y[m_g] + m_h[m_g] - 1 : SH - 1;
      for (int yy = m_y[m_g]; yy <= ye; yy++) begin
        for (int xx = m_x[m_g]; xx <= xe; xx++) begin
          m_wr_addr[t] = yy * SW + xx;
          m_wr_data[t] = m_c[m_g];
          t++;
        end
      end
    end
    m_fin = t;
    m_done[t] = 1 << m_g;
    m_ptr = (m_g + 1) % NREQ;
    m_insvc = 1'b1;
    m_grant = -1;
  endtask

  initial begin
    cyc = 0;
    model_clear();
    forever begin
      @(posedge Clck or negedge Resetn);
      if (!Resetn) begin
        model_clear();
      end else begin
        cyc++;
        for (int k = 0; k < NREQ; k++) acc[k] = start[k] && !m_pend[k];
        if (cyc == m_rel) m_pend[m_relg] = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (acc[k]) begin
            m_pend[k] = 1'b1;
            m_x[k] = int'(cmd_x[k*CW +: CW]);
            m_y[k] = int'(cmd_y[k*CW +: CW]);
            m_w[k] = int'(cmd_w[k*CW +: CW]);
            m_h[k] = int'(cmd_h[k*CW +: CW]);
            m_c[k] = int'(cmd_color[k*3 +: 3]);
          end
        end
        if (cyc == m_grant) model_grant();
        anyp = 1'b0;
        others = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (m_pend[k]) anyp = 1'b1;
          if (m_pend[k] && k != m_g) others = 1'b1;
        end
        if (m_insvc && cyc == m_fin) begin
          m_insvc = 1'b0;
          m_rel = cyc + 1;
          m_relg = m_g;
          if (others) m_grant = cyc + 1;
        end else if (!m_insvc && m_grant < 0 && anyp) begin
          m_grant = cyc + 1;
        end
      end
    end
  end

  // ---------------- compare and logging ----------------
  int wr_log [$];
  int wd_log [$];
  int done_log [$];
  int done_cyc [$];
  bit ew;
  int ed;
  logic [NREQ-1:0] eb;

  initial begin
    forever begin
      @(negedge Clck);
      if (chk_en) begin
        ew = m_wr_addr.exists(cyc);
        check("wren", 32'(mem_wren), 32'(ew));
        if (ew) begin
          check("addr", 32'(mem_address), m_wr_addr[cyc]);
          check("data", 32'(mem_data), m_wr_data[cyc]);
        end
        ed = m_done.exists(cyc) ? m_done[cyc] : 0;
        check("done", 32'(done), ed);
        for (int k = 0; k < NREQ; k++) eb[k] = m_pend[k];
        check("busy", 32'(busy), 32'(eb));
      end
      if (mem_wren === 1'b1) begin
        wr_log.push_back(int'(mem_address));
        wd_log.push_back(int'(mem_data));
        check("addr_in_range", 32'(mem_address < 11'd1122), 1);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (done[k] === 1'b1) begin
          done_log.push_back(k);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge Clck);
    #1;
  endtask

  task automatic set_cmd(input int k, input int x, input int y, input int w, input int h,
                         input int c);
    cmd_x[k*CW +: CW]   = CW'(x);
    cmd_y[k*CW +: CW]   = CW'(y);
    cmd_w[k*CW +: CW]   = CW'(w);
    cmd_h[k*CW +: CW]   = CW'(h);
    cmd_color[k*3 +: 3] = 3'(c);
  endtask

  task automatic issue(input logic [NREQ-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (busy != '0 && n < budget) begin
      tick();
      n++;
    end
    check("quiet_timeout", 32'(busy), 0);
    tick();
  endtask

  task automatic clear_logs();
    wr_log.delete(); wd_log.delete(); done_log.delete(); done_cyc.delete();
  endtask

  int exp1 [6] = '{36, 37, 38, 70, 71, 72};
  int exp2 [4] = '{1086, 1087, 1120, 1121};
  int t0;
  int n;

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    Resetn = 1'b0; start = '0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wren", 32'(mem_wren), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_data", 32'(mem_data), 0);
    Resetn = 1'b1;
    chk_en = 1'b1;
    tick();

    // Basic 3x2 fill.
    clear_logs();
    set_cmd(0, 2, 1, 3, 2, 5);
    t0 = cyc;
    issue(2'b01);
    wait_quiet(100);
    check("t1_count", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t1_addr", wr_log[i], exp1[i]);
      check("t1_data", wd_log[i], 5);
    end
    check("t1_latency", done_cyc[0] - t0, 9);
    check("t1_done_who", done_log[0], 0);

    // Clipped at bottom-right corner.
    clear_logs();
    set_cmd(1, 32, 31, 10, 10, 3);
    issue(2'b10);
    wait_quiet(100);
    check("clip_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) check("clip_addr", wr_log[i], exp2[i]);
    check("clip_done_who", done_log[0], 1);

    // Simultaneous pair with pointer at 0.
    clear_logs();
    set_cmd(0, 0, 0, 2, 1, 1);
    set_cmd(1, 5, 5, 1, 2, 2);
    issue(2'b11);
    wait_quiet(100);
    check("pair0_done_n", done_log.size(), 2);
    check("pair0_first", done_log[0], 0);
    check("pair0_second", done_log[1], 1);
    check("pair0_wr0", wr_log[0], 0);
    check("pair0_wr2", wr_log[2], 175);

    // Zero width: done two cycles after grant path, no writes.
    clear_logs();
    set_cmd(0, 3, 3, 0, 4, 7);
    t0 = cyc;
    issue(2'b01);
    wait_quiet(100);
    check("w0_count", wr_log.size(), 0);
    check("w0_latency", done_cyc[0] - t0, 3);

    // Second simultaneous pair, pointer now at 1.
    clear_logs();
    set_cmd(0, 0, 0, 2, 1, 1);
    set_cmd(1, 5, 5, 1, 2, 2);
    issue(2'b11);
    wait_quiet(100);
    check("pair1_first", done_log[0], 1);
    check("pair1_second", done_log[1], 0);

    // Off-screen x.
    clear_logs();
    set_cmd(0, 40, 2, 3, 3, 6);
    t0 = cyc;
    issue(2'b01);
    wait_quiet(100);
    check("x40_count", wr_log.size(), 0);
    check("x40_latency", done_cyc[0] - t0, 3);

    // Re-pulse while busy is ignored.
    clear_logs();
    set_cmd(0, 1, 2, 4, 3, 4);
    issue(2'b01);
    repeat (3) tick();
    set_cmd(0, 9, 9, 9, 9, 1);
    issue(2'b01);
    wait_quiet(100);
    check("redo_done_n", done_log.size(), 1);
    check("redo_count", wr_log.size(), 12);
    check("redo_data", wd_log[11], 4);

    // Reset during the third write of a 3x3 fill.
    clear_logs();
    set_cmd(0, 0, 0, 3, 3, 2);
    issue(2'b01);
    n = 0;
    while (wr_log.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    check("mid_reached", wr_log.size(), 3);
    Resetn = 1'b0;
    #1;
    check("mid_wren", 32'(mem_wren), 0);
    check("mid_busy", 32'(busy), 0);
    repeat (2) tick();
    Resetn = 1'b1;
    repeat (4) tick();
    check("mid_no_done", done_log.size(), 0);
    clear_logs();
    set_cmd(1, 10, 10, 2, 2, 1);
    issue(2'b10);
    wait_quiet(100);
    check("post_count", wr_log.size(), 4);
    check("post_addr0", wr_log[0], 350);
    check("post_done_who", done_log[0], 1);

    // Randomized traffic; fields churn every cycle so only accepted starts matter.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 31) == 0)
          set_cmd(k, $urandom_range(0, 10), $urandom_range(0, 10), 63, 63, $urandom_range(0, 7));
        else
          set_cmd(k, $urandom_range(0, 40), $urandom_range(0, 38), $urandom_range(0, 12),
                  $urandom_range(0, 12), $urandom_range(0, 7));
        start[k] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    start = '0;
    wait_quiet(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
